// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN bias path.
//   bias_state_e       : control states of the bias loader
//   BIAS_*_DEFAULT     : default feature count and bias word width
//   bias_idx_width()   : width of the word index for a given feature count
// ---------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } bias_state_e;

    localparam int BIAS_NUM_FEATURES_DEFAULT = 3;
    localparam int BIAS_DATA_WIDTH_DEFAULT   = 32;

    // A single-word load (no features) still needs a 1-bit index.
    function automatic int bias_idx_width(input int num_features);
        return (num_features > 0) ? $clog2(num_features + 1) : 1;
    endfunction

endpackage

// File: rtl/bias_loader.sv
// ---------------------------------------------------------------------------
// bias_loader
// Collects NUM_FEATURES+1 signed bias words from a valid/ready stream into a
// staging array, then issues a single-cycle active-low write strobe so the
// bias memory captures the whole set at once.
//
// Ports
//   clk                 : clock, all state updates on posedge
//   rst                 : asynchronous active-low reset
//   start               : request a new load, only looked at in IDLE
//   in_valid/in_ready   : stream handshake, word taken when both are high
//   in_data             : signed stream word
//   bias_WrEn           : active-low memory write strobe, low only in COMMIT
//   bias_weights_staged : assembled bias words
//   busy                : high whenever not IDLE
//   done                : one-cycle pulse after a commit
//   err                 : one-cycle pulse on checksum mismatch
//
// Build option
//   BIAS_LOADER_CHECKSUM_EN : when defined, one extra stream word after the
//   biases carries their modulo-2^BIAS_DATA_WIDTH sum; a mismatch drops the
//   load without touching the memory. When undefined, err is tied low.
// ---------------------------------------------------------------------------
module bias_loader
    import cnn_pkg::*;
#(
    parameter int NUM_FEATURES    = BIAS_NUM_FEATURES_DEFAULT,
    parameter int BIAS_DATA_WIDTH = BIAS_DATA_WIDTH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [BIAS_DATA_WIDTH-1:0] in_data,
    output logic                              bias_WrEn,
    output logic signed [BIAS_DATA_WIDTH-1:0] bias_weights_staged [NUM_FEATURES+1],
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int                IDX_W    = bias_idx_width(NUM_FEATURES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEATURES);

    bias_state_e                       state_q, state_d;
    logic        [IDX_W-1:0]           idx_q, idx_d;
    logic signed [BIAS_DATA_WIDTH-1:0] staged_q [NUM_FEATURES+1];
    logic signed [BIAS_DATA_WIDTH-1:0] staged_d [NUM_FEATURES+1];
`ifdef BIAS_LOADER_CHECKSUM_EN
    logic signed [BIAS_DATA_WIDTH-1:0] sum_q, sum_d;
    logic                              err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_FEATURES + 1; i++) begin
                staged_q[i] <= '0;
            end
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            staged_q <= staged_d;
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
            err_q    <= err_d;
`endif
        end
    end

    // in_ready is only high in LOAD and CHECK, so in those states an accepted
    // word is simply in_valid.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        staged_d = staged_q;
`ifdef BIAS_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (in_valid) begin
                    staged_d[idx_q] = in_data;
`ifdef BIAS_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = COMMIT;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef BIAS_LOADER_CHECKSUM_EN
            // A bad checksum abandons the load; the staged words are left
            // as-is but never strobed into memory.
            CHECK: begin
                if (in_valid) begin
                    if (in_data == sum_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            COMMIT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe comes straight from the registered state so it is glitch-free
    // and stable for the whole COMMIT cycle, including the negedge capture.
    assign in_ready            = (state_q == LOAD) || (state_q == CHECK);
    assign bias_WrEn           = (state_q != COMMIT);
    assign busy                = (state_q != IDLE);
    assign done                = (state_q == DONE);
    assign bias_weights_staged = staged_q;
`ifdef BIAS_LOADER_CHECKSUM_EN
    assign err                 = err_q;
`else
    assign err                 = 1'b0;
`endif

endmodule

// File: tb/tb_bias_loader.sv
// ---------------------------------------------------------------------------
// tb_bias_loader
// Directed self-checking bench for bias_loader (NUM_FEATURES=3, 32-bit).
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
// ctl is {in_ready, bias_WrEn, busy, done, err}:
//   IDLE 01000, LOAD/CHECK 11100, COMMIT 00100, DONE 01110, err pulse 01001.
// When BIAS_LOADER_CHECKSUM_EN is defined, each load is followed by its
// checksum word, and an extra 8-bit instance checks modular wrap.
// ---------------------------------------------------------------------------
module tb_bias_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_data;
    logic               bias_WrEn;
    logic signed [31:0] staged [4];
    logic               busy;
    logic               done;
    logic               err;

    int checks = 0;
    int errors = 0;

    logic [4:0] ctl;
    assign ctl = {in_ready, bias_WrEn, busy, done, err};

    logic signed [31:0] basic_w [4] = '{32'sd10, -32'sd20, 32'sd30, -32'sd40};
    int                 stall_pat [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    bias_loader #(
        .NUM_FEATURES    (3),
        .BIAS_DATA_WIDTH (32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .bias_WrEn           (bias_WrEn),
        .bias_weights_staged (staged),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

`ifdef BIAS_LOADER_CHECKSUM_EN
    logic              start8;
    logic              valid8;
    logic              ready8;
    logic signed [7:0] data8;
    logic              wren8;
    logic signed [7:0] staged8 [4];
    logic              busy8;
    logic              done8;
    logic              err8;
    logic [4:0]        ctl8;
    assign ctl8 = {ready8, wren8, busy8, done8, err8};

    bias_loader #(
        .NUM_FEATURES    (3),
        .BIAS_DATA_WIDTH (8)
    ) dut8 (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start8),
        .in_valid            (valid8),
        .in_ready            (ready8),
        .in_data             (data8),
        .bias_WrEn           (wren8),
        .bias_weights_staged (staged8),
        .busy                (busy8),
        .done                (done8),
        .err                 (err8)
    );
`endif

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives four words back to back, one per cycle, leaving in_valid low.
    task automatic load_four(input logic signed [31:0] a, b, c, d);
        logic signed [31:0] w [4];
        w = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            step;
        end
        in_valid = 1'b0;
    endtask

    // With checksums enabled the loader sits in CHECK after the last word;
    // feed it the matching sum so the common commit checks apply.
    task automatic pass_check(input logic signed [31:0] sum);
`ifdef BIAS_LOADER_CHECKSUM_EN
        checks++;
        if (ctl !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL check_state ctl got %b expected %b", ctl, 5'b11100);
        end
        in_valid = 1'b1;
        in_data  = sum;
        step;
        in_valid = 1'b0;
`else
        in_data = sum;
`endif
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
        start8 = 1'b0; valid8 = 1'b0; data8 = '0;
`endif
        #3;
        checks++;
        if (ctl !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL reset_ctl got %b expected %b", ctl, 5'b01000);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (staged[i] !== 32'sd0) begin
                errors++;
                $display("[TB] FAIL reset_staged[%0d] got %0d expected 0", i, staged[i]);
            end
        end
        step;
        rst = 1'b1;
        step;
        checks++;
        if (ctl !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL post_reset_ctl got %b expected %b", ctl, 5'b01000);
        end
    endtask

    task automatic test_basic_load;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (ctl !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL basic_load_state ctl got %b expected %b", ctl, 5'b11100);
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = basic_w[k];
            step;
            if (k < 3) begin
                checks++;
                if (ctl !== 5'b11100) begin
                    errors++;
                    $display("[TB] FAIL basic_word%0d ctl got %b expected %b", k, ctl, 5'b11100);
                end
            end
        end
        in_valid = 1'b0;
        pass_check(-32'sd20);
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL basic_commit ctl got %b expected %b", ctl, 5'b00100);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (staged[i] !== basic_w[i]) begin
                errors++;
                $display("[TB] FAIL basic_staged[%0d] got %0d expected %0d", i, staged[i], basic_w[i]);
            end
        end
        step;
        checks++;
        if (ctl !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL basic_done ctl got %b expected %b", ctl, 5'b01110);
        end
        step;
        checks++;
        if (ctl !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL basic_idle ctl got %b expected %b", ctl, 5'b01000);
        end
    endtask

    task automatic test_stalls;
        int k;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (stall_pat[c] != 0);
            in_data  = in_valid ? basic_w[k] : 32'sd999;
            step;
            if (in_valid) begin
                checks++;
                if (staged[k] !== basic_w[k]) begin
                    errors++;
                    $display("[TB] FAIL stall_staged[%0d] got %0d expected %0d", k, staged[k], basic_w[k]);
                end
                if (k < 3) begin
                    checks++;
                    if (staged[k+1] !== 32'sd0) begin
                        errors++;
                        $display("[TB] FAIL stall_next[%0d] got %0d expected 0", k + 1, staged[k+1]);
                    end
                end
                k++;
            end else begin
                checks++;
                if (ctl !== 5'b11100) begin
                    errors++;
                    $display("[TB] FAIL stall_gap%0d ctl got %b expected %b", c, ctl, 5'b11100);
                end
            end
        end
        in_valid = 1'b0;
        pass_check(-32'sd20);
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL stall_commit ctl got %b expected %b", ctl, 5'b00100);
        end
        step;
        step;
    endtask

    task automatic test_reset_mid_load;
        start = 1'b1;
        step;
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'sd55;
        step;
        in_data = 32'sd66;
        step;
        in_data = 32'sd77;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL midreset_ctl got %b expected %b", ctl, 5'b01000);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (staged[i] !== 32'sd0) begin
                errors++;
                $display("[TB] FAIL midreset_staged[%0d] got %0d expected 0", i, staged[i]);
            end
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step;
            checks++;
            if (ctl !== 5'b01000) begin
                errors++;
                $display("[TB] FAIL midreset_after%0d ctl got %b expected %b", c, ctl, 5'b01000);
            end
        end
    endtask

    // start stays high for the whole load: it must neither restart the index
    // nor redirect COMMIT away from DONE.
    task automatic test_start_ignored;
        start = 1'b1;
        step;
        load_four(32'sd1, 32'sd2, 32'sd3, 32'sd4);
        pass_check(32'sd10);
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL ignore_commit ctl got %b expected %b", ctl, 5'b00100);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (staged[i] !== 32'(i + 1)) begin
                errors++;
                $display("[TB] FAIL ignore_staged[%0d] got %0d expected %0d", i, staged[i], i + 1);
            end
        end
        step;
        checks++;
        if (ctl !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL ignore_done ctl got %b expected %b", ctl, 5'b01110);
        end
        start = 1'b0;
        step;
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        step;
        start = 1'b0;
        load_four(32'sd21, 32'sd22, 32'sd23, 32'sd24);
        pass_check(32'sd90);
        step;
        checks++;
        if (ctl !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL b2b_done1 ctl got %b expected %b", ctl, 5'b01110);
        end
        start = 1'b1;
        step;
        checks++;
        if (ctl !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL b2b_idle ctl got %b expected %b", ctl, 5'b01000);
        end
        step;
        start = 1'b0;
        checks++;
        if (ctl !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL b2b_reload ctl got %b expected %b", ctl, 5'b11100);
        end
        load_four(32'sd7, 32'sd8, 32'sd9, 32'sd10);
        pass_check(32'sd34);
        checks++;
        if (ctl !== 5'b00100 || staged[0] !== 32'sd7 || staged[3] !== 32'sd10) begin
            errors++;
            $display("[TB] FAIL b2b_commit2 ctl got %b expected %b, staged0 %0d/7 staged3 %0d/10",
                     ctl, 5'b00100, staged[0], staged[3]);
        end
        step;
        step;
    endtask

`ifdef BIAS_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        start = 1'b1;
        step;
        start = 1'b0;
        load_four(32'sd1, 32'sd2, 32'sd3, 32'sd4);
        pass_check(32'sd10);
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL cksum_pass ctl got %b expected %b", ctl, 5'b00100);
        end
        step;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        load_four(32'sd1, 32'sd2, 32'sd3, 32'sd4);
        in_valid = 1'b1;
        in_data  = 32'sd11;
        step;
        in_valid = 1'b0;
        checks++;
        if (ctl !== 5'b01001) begin
            errors++;
            $display("[TB] FAIL cksum_bad ctl got %b expected %b", ctl, 5'b01001);
        end
        step;
        checks++;
        if (ctl !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL cksum_bad_after ctl got %b expected %b", ctl, 5'b01000);
        end
    endtask

    task automatic test_checksum_wrap;
        start8 = 1'b1;
        step;
        start8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid8 = 1'b1;
            data8  = 8'sd127;
            step;
        end
        data8 = 8'shFC;
        step;
        valid8 = 1'b0;
        checks++;
        if (ctl8 !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL cksum_wrap ctl got %b expected %b", ctl8, 5'b00100);
        end
        step;
        step;
    endtask
`endif

    initial begin
        test_reset;
        test_basic_load;
        test_stalls;
        test_reset_mid_load;
        test_start_ignored;
        test_back_to_back;
`ifdef BIAS_LOADER_CHECKSUM_EN
        test_checksum;
        test_checksum_wrap;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
